imem_loader: RTL and testbench

- Byte-serial program writer for the tiny processor's 16x8 instruction memory.
- An external host, driving the pin inputs, streams instruction bytes into the loader. The loader turns them into single-cycle write strobes on the imem write port.
- While it is loading, the loader holds the processor core. When it finishes or aborts, it issues a core restart so execution begins from pc 0.

---
 rtl/imem_loader.sv | 185 ++++++++++++++++++
 tb/tb_imem_loader.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-serial host writer for the instruction memory; holds the core while loading.
// Optional trailing-checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int IMEM_SZ = 16,
    parameter int INST_W  = 8,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en_in,
    input  logic              strobe_in,
    input  logic [INST_W-1:0] data_in,
    output logic              wr_en_out,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [INST_W-1:0] wr_data_out,
    output logic              cpu_hold_out,
    output logic              cpu_restart_out,
    output logic              done_out,
    output logic [ADDR_W:0]   count_out,
    output logic              error_out
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, LOAD, CHECK, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(IMEM_SZ);

    state_t state, state_d;

    logic load_s1, load_s2;
    logic stb_s1, stb_s2, stb_s3;
    logic strobe_rise;

    logic [ADDR_W-1:0] addr, addr_d;
    logic [ADDR_W:0]   count_d;
    logic [ADDR_W:0]   count_inc;
    logic              wr_en_d, hold_d, restart_d, done_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [INST_W-1:0] wr_data_d;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INST_W-1:0] sum, sum_d;
    logic [INST_W-1:0] sum_total;
    logic              err_d;
`endif

    // Host pins are asynchronous; the third strobe flop gives a clean rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_s1 <= 1'b0;
            load_s2 <= 1'b0;
            stb_s1  <= 1'b0;
            stb_s2  <= 1'b0;
            stb_s3  <= 1'b0;
        end else begin
            load_s1 <= load_en_in;
            load_s2 <= load_s1;
            stb_s1  <= strobe_in;
            stb_s2  <= stb_s1;
            stb_s3  <= stb_s2;
        end
    end

    assign strobe_rise = stb_s2 & ~stb_s3;
    assign count_inc   = (count_out == FULL) ? count_out : count_out + 1'b1;

`ifdef IMEM_LOADER_CHECKSUM_EN
    assign sum_total = sum + data_in;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            addr            <= '0;
            count_out       <= '0;
            wr_en_out       <= 1'b0;
            wr_addr_out     <= '0;
            wr_data_out     <= '0;
            cpu_hold_out    <= 1'b0;
            cpu_restart_out <= 1'b0;
            done_out        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum             <= '0;
            error_out       <= 1'b0;
`endif
        end else begin
            state           <= state_d;
            addr            <= addr_d;
            count_out       <= count_d;
            wr_en_out       <= wr_en_d;
            wr_addr_out     <= wr_addr_d;
            wr_data_out     <= wr_data_d;
            cpu_hold_out    <= hold_d;
            cpu_restart_out <= restart_d;
            done_out        <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum             <= sum_d;
            error_out       <= err_d;
`endif
        end
    end

`ifndef IMEM_LOADER_CHECKSUM_EN
    assign error_out = 1'b0;
`endif

    always_comb begin
        state_d   = state;
        addr_d    = addr;
        count_d   = count_out;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_out;
        wr_data_d = wr_data_out;
        hold_d    = cpu_hold_out;
        restart_d = 1'b0;
        done_d    = done_out;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d     = sum;
        err_d     = error_out;
`endif
        unique case (state)
            IDLE: begin
                if (load_s2) begin
                    state_d = LOAD;
                    addr_d  = '0;
                    count_d = '0;
                    done_d  = 1'b0;
                    hold_d  = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (!load_s2) begin
                    state_d   = IDLE;
                    hold_d    = 1'b0;
                    restart_d = 1'b1;
                end else if (strobe_rise) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr;
                    wr_data_d = data_in;
                    addr_d    = addr + 1'b1;
                    count_d   = count_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d     = sum_total;
                    if (count_inc == FULL) state_d = CHECK;
`else
                    if (count_inc == FULL) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (!load_s2) begin
                    state_d   = IDLE;
                    hold_d    = 1'b0;
                    restart_d = 1'b1;
                end else if (strobe_rise) begin
                    // Checksum byte closes the image; it never reaches imem.
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = (sum_total != '0);
                end
            end
`endif
            DONE: begin
                if (!load_s2) begin
                    state_d   = IDLE;
                    hold_d    = 1'b0;
                    restart_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: per-cycle model compare plus literal checks.
// Define IMEM_LOADER_CHECKSUM_EN for both files to exercise the checksum path.
module tb_imem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_en = 1'b0;
    logic       strobe = 1'b0;
    logic [7:0] data = 8'h00;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       hold, restart, done, err;
    logic [4:0] count;

    imem_loader dut (
        .clk(clk), .rst_n(rst_n), .load_en_in(load_en), .strobe_in(strobe),
        .data_in(data), .wr_en_out(wr_en), .wr_addr_out(wr_addr),
        .wr_data_out(wr_data), .cpu_hold_out(hold), .cpu_restart_out(restart),
        .done_out(done), .count_out(count), .error_out(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [7:0] image [16] = '{8'h1B, 8'h17, 8'h30, 8'h41, 8'h52, 8'h63, 8'h74, 8'h85,
                               8'h96, 8'hA7, 8'hB8, 8'hC9, 8'hDA, 8'hEB, 8'h68, 8'h00};

    // Host-visible model: inputs reach the loader two edges late, a byte lands
    // one edge after its strobe edge is seen; modes follow the load protocol.
    int  mode;
    int  m_addr, m_sum;
    bit  l1, l2, s1, s2, s3;
    bit  e_wr, e_hold, e_rst, e_done, e_err;
    int  e_addr, e_data, e_cnt;

    task automatic model_clear();
        mode = 0; m_addr = 0; m_sum = 0;
        l1 = 0; l2 = 0; s1 = 0; s2 = 0; s3 = 0;
        e_wr = 0; e_hold = 0; e_rst = 0; e_done = 0; e_err = 0;
        e_addr = 0; e_data = 0; e_cnt = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_clear();
        end else begin
            e_wr = 0;
            e_rst = 0;
            case (mode)
                0: if (l2) begin
                    mode = 1; e_cnt = 0; m_addr = 0; e_done = 0; e_err = 0; m_sum = 0;
                end
                1: if (!l2) begin
                    mode = 0; e_rst = 1;
                end else if (s2 && !s3) begin
                    e_wr = 1; e_addr = m_addr; e_data = data;
                    m_addr = (m_addr + 1) % 16;
                    e_cnt = e_cnt + 1;
                    m_sum = (m_sum + data) % 256;
                    if (e_cnt == 16) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        mode = 2;
`else
                        mode = 3; e_done = 1;
`endif
                    end
                end
                2: if (!l2) begin
                    mode = 0; e_rst = 1;
                end else if (s2 && !s3) begin
                    e_err = ((m_sum + data) % 256) != 0;
                    mode = 3; e_done = 1;
                end
                default: if (!l2) begin
                    mode = 0; e_rst = 1;
                end
            endcase
            e_hold = (mode != 0);
            l2 = l1; l1 = load_en;
            s3 = s2; s2 = s1; s1 = strobe;
        end
    end

    int cyc = 0;
    int wr_cnt = 0;
    int rst_cnt = 0;
    int last_wr_cyc = -1;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;
    logic [7:0] shadow [16];

    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        chk("cycle_outputs",
            {10'd0, wr_en, wr_addr, wr_data, hold, restart, done, count, err},
            {10'd0, e_wr, e_addr[3:0], e_data[7:0], e_hold, e_rst, e_done,
             e_cnt[4:0], e_err});
        if (wr_en) begin
            wr_cnt++;
            shadow[wr_addr] = wr_data;
            last_wr_cyc = cyc;
            last_addr = wr_addr;
            last_data = wr_data;
        end
        if (restart) rst_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk) data = b;
        @(negedge clk) strobe = 1'b1;
        repeat (4) @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_load(input logic v);
        @(negedge clk) load_en = v;
        repeat (6) @(negedge clk);
    endtask

    task automatic full_load(input logic [7:0] ck);
        for (int i = 0; i < 16; i++) send_byte(image[i]);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(ck);
`else
        if (ck == 8'hFF) send_byte(8'h00);
`endif
    endtask

    int w0, r0, k;

    initial begin
        model_clear();
        repeat (3) @(negedge clk);
        chk("reset_state", {wr_en, wr_addr, wr_data, hold, restart, done, count, err}, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full image load
        w0 = wr_cnt;
        set_load(1'b1);
        chk("hold_in_load", hold, 1);
        full_load(8'hC4);
        chk("full_writes", wr_cnt - w0, 16);
        chk("full_done", done, 1);
        chk("full_count", count, 16);
        chk("full_err", err, 0);
        for (int i = 0; i < 16; i++) chk($sformatf("imem_%0d", i), shadow[i], image[i]);

        // Extra strobe while DONE
        send_byte(8'hEE);
        chk("done_ignores", wr_cnt - w0, 16);
        chk("done_shadow15", shadow[15], 8'h00);

        // Leave DONE
        r0 = rst_cnt;
        set_load(1'b0);
        chk("restart_once", rst_cnt - r0, 1);
        chk("hold_idle", hold, 0);
        w0 = wr_cnt;
        send_byte(8'h11);
        send_byte(8'h22);
        chk("idle_no_write", wr_cnt - w0, 0);

        // Abort after five bytes
        w0 = wr_cnt;
        r0 = rst_cnt;
        set_load(1'b1);
        for (int i = 0; i < 5; i++) send_byte(8'h40 + 8'(i));
        chk("abort_writes", wr_cnt - w0, 5);
        chk("abort_last_addr", last_addr, 4);
        chk("abort_count", count, 5);
        set_load(1'b0);
        chk("abort_restart", rst_cnt - r0, 1);
        chk("abort_done", done, 0);

        // Reload after abort; first byte exercises strobe-to-write latency
        set_load(1'b1);
        @(negedge clk) data = 8'hA5;
        @(negedge clk) strobe = 1'b1;
        k = cyc + 1;
        repeat (4) @(negedge clk);
        strobe = 1'b0;
        repeat (4) @(negedge clk);
        chk("latency", last_wr_cyc - k, 2);
        chk("latency_data", last_data, 8'hA5);
        chk("reload_addr", last_addr, 0);
        set_load(1'b0);

        // Reset mid-load at count 7
        set_load(1'b1);
        for (int i = 0; i < 7; i++) send_byte(8'h70 + 8'(i));
        chk("pre_reset_count", count, 7);
        r0 = rst_cnt;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {wr_en, wr_addr, wr_data, hold, restart, done, count, err}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("reset_no_restart", rst_cnt - r0, 0);
        w0 = wr_cnt;
        send_byte(8'h5A);
        chk("post_reset_write", wr_cnt - w0, 1);
        chk("post_reset_addr", last_addr, 0);
        set_load(1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Bad checksum
        w0 = wr_cnt;
        set_load(1'b1);
        full_load(8'hC5);
        chk("bad_ck_writes", wr_cnt - w0, 16);
        chk("bad_ck_done", done, 1);
        chk("bad_ck_err", err, 1);
        set_load(1'b0);
        chk("err_sticky_idle", err, 1);
        set_load(1'b1);
        chk("err_clear_load", err, 0);
        set_load(1'b0);
`endif

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
